// File: rtl/traffic_phase_controller.sv
// Traffic phase controller: one main street, NUM_SIDE side streets and a walk phase,
// with an integrated interval timer and run-time programmable interval registers.
module traffic_phase_controller #(
    parameter int NUM_SIDE = 2,
    parameter int CNT_W    = 4,
    parameter int T_BASE   = 6,
    parameter int T_EXT    = 3,
    parameter int T_YEL    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [NUM_SIDE-1:0] traffic_sensor,
    input  logic                walk_req,
    input  logic                reprogram,
    input  logic [1:0]          prog_sel,
    input  logic [CNT_W-1:0]    prog_value,
    output logic                Gm,
    output logic                Ym,
    output logic                Rm,
    output logic [NUM_SIDE-1:0] Gs,
    output logic [NUM_SIDE-1:0] Ys,
    output logic [NUM_SIDE-1:0] Rs,
    output logic                W,
    output logic [2:0]          phase,
    output logic [2:0]          side_idx
);
    typedef enum logic [2:0] {
        MAIN_G1 = 3'd0,
        MAIN_G2 = 3'd1,
        MAIN_Y  = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_Y  = 3'd4,
        WALK    = 3'd5
    } phase_e;

    phase_e              state_q, state_d;
    logic [2:0]          side_q, side_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ext_q, ext_d;
    logic [NUM_SIDE-1:0] pend_q, pend_d, clr_side;
    logic                walk_q, walk_d;
    logic [CNT_W-1:0]    t_base_q, t_ext_q, t_yel_q, base_new;
    logic [7:0]          sensor_w;
    logic                lo_found, nx_found, enter_side, enter_walk;
    logic [2:0]          lo_idx, nx_idx;

    // An interval of 0 behaves as 1: the counter then expires on the first tick.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    assign sensor_w = 8'(traffic_sensor);
    assign base_new = (reprogram && prog_sel == 2'd0) ? prog_value : t_base_q;
    assign pend_d   = (pend_q & ~clr_side) | traffic_sensor;
    assign walk_d   = (walk_q & ~enter_walk) | walk_req;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MAIN_G1;
            side_q   <= '0;
            count_q  <= load_val(CNT_W'(T_BASE));
            ext_q    <= 1'b0;
            pend_q   <= '0;
            walk_q   <= 1'b0;
            t_base_q <= CNT_W'(T_BASE);
            t_ext_q  <= CNT_W'(T_EXT);
            t_yel_q  <= CNT_W'(T_YEL);
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            count_q <= count_d;
            ext_q   <= ext_d;
            pend_q  <= pend_d;
            walk_q  <= walk_d;
            if (reprogram) begin
                case (prog_sel)
                    2'd0:    t_base_q <= prog_value;
                    2'd1:    t_ext_q  <= prog_value;
                    2'd2:    t_yel_q  <= prog_value;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        side_d     = side_q;
        count_d    = count_q;
        ext_d      = ext_q;
        enter_side = 1'b0;
        enter_walk = 1'b0;
        lo_found   = 1'b0;
        lo_idx     = '0;
        nx_found   = 1'b0;
        nx_idx     = '0;
        clr_side   = '0;
        // Scan downwards so the last hit is the lowest qualifying index.
        for (int i = NUM_SIDE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
            end
            if (pend_q[i] && 3'(i) > side_q) begin
                nx_found = 1'b1;
                nx_idx   = 3'(i);
            end
        end
        if (reprogram) begin
            state_d = MAIN_G1;
            count_d = load_val(base_new);
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                case (state_q)
                    MAIN_G1: begin
                        if ((|pend_q) || walk_q) begin
                            state_d = MAIN_G2;
                            count_d = load_val(t_ext_q);
                        end else begin
                            count_d = load_val(t_base_q);
                        end
                    end
                    MAIN_G2: begin
                        state_d = MAIN_Y;
                        count_d = load_val(t_yel_q);
                    end
                    MAIN_Y: begin
                        if (lo_found) begin
                            state_d    = SIDE_G;
                            side_d     = lo_idx;
                            enter_side = 1'b1;
                        end else begin
                            state_d    = WALK;
                            enter_walk = 1'b1;
                        end
                    end
                    SIDE_G: begin
                        if (!ext_q && sensor_w[side_q]) begin
                            count_d = load_val(t_ext_q);
                            ext_d   = 1'b1;
                        end else begin
                            state_d = SIDE_Y;
                            count_d = load_val(t_yel_q);
                        end
                    end
                    SIDE_Y: begin
                        if (nx_found) begin
                            state_d    = SIDE_G;
                            side_d     = nx_idx;
                            enter_side = 1'b1;
                        end else if (walk_q) begin
                            state_d    = WALK;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = MAIN_G1;
                            count_d = load_val(t_base_q);
                        end
                    end
                    default: begin
                        state_d = MAIN_G1;
                        count_d = load_val(t_base_q);
                    end
                endcase
                if (enter_side) begin
                    count_d = load_val(t_base_q);
                    ext_d   = 1'b0;
                    for (int i = 0; i < NUM_SIDE; i++) begin
                        clr_side[i] = (side_d == 3'(i));
                    end
                end
                if (enter_walk) begin
                    count_d = load_val(t_ext_q);
                end
            end
        end
    end

    always_comb begin
        Gm       = (state_q == MAIN_G1) || (state_q == MAIN_G2);
        Ym       = (state_q == MAIN_Y);
        Rm       = !((state_q == MAIN_G1) || (state_q == MAIN_G2) || (state_q == MAIN_Y));
        W        = (state_q == WALK);
        phase    = state_q;
        side_idx = side_q;
        Gs       = '0;
        Ys       = '0;
        for (int i = 0; i < NUM_SIDE; i++) begin
            Gs[i] = (state_q == SIDE_G) && (side_q == 3'(i));
            Ys[i] = (state_q == SIDE_Y) && (side_q == 3'(i));
        end
        Rs = ~(Gs | Ys);
    end
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: a tick-counting reference model queues
// the expected lamps for every edge and a monitor compares them after the edge.
module tb_traffic_phase_controller;
    localparam int NS = 2;
    localparam int CW = 4;
    localparam int TB = 6;
    localparam int TE = 3;
    localparam int TY = 2;

    logic          clk = 1'b0;
    logic          reset, tick, walk_req, reprogram;
    logic [NS-1:0] traffic_sensor;
    logic [1:0]    prog_sel;
    logic [CW-1:0] prog_value;
    logic          Gm, Ym, Rm, W;
    logic [NS-1:0] Gs, Ys, Rs;
    logic [2:0]    phase, side_idx;

    traffic_phase_controller #(
        .NUM_SIDE(NS), .CNT_W(CW), .T_BASE(TB), .T_EXT(TE), .T_YEL(TY)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .traffic_sensor(traffic_sensor),
        .walk_req(walk_req), .reprogram(reprogram), .prog_sel(prog_sel),
        .prog_value(prog_value), .Gm(Gm), .Ym(Ym), .Rm(Rm), .Gs(Gs), .Ys(Ys),
        .Rs(Rs), .W(W), .phase(phase), .side_idx(side_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] lamps;
        logic [2:0]  side;
        logic        chk_side;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: phase number, side served, expiring ticks still to go in this phase.
    int          m_ph, m_side, m_left, m_base, m_ext, m_yel;
    bit          m_ext_used, m_walk;
    bit [NS-1:0] m_pend;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int next_pending(input bit [NS-1:0] p, input int after);
        for (int i = after + 1; i < NS; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit [NS-1:0] old_p = m_pend;
        bit          old_w = m_walk;
        bit [NS-1:0] clr   = '0;
        bit          wclr  = 1'b0;
        int          k;
        if (!reset) begin
            m_base = TB; m_ext = TE; m_yel = TY;
            m_ph = 0; m_side = 0; m_left = eff(TB);
            m_ext_used = 1'b0; m_pend = '0; m_walk = 1'b0;
            return;
        end
        if (reprogram) begin
            if (prog_sel == 2'd0) m_base = int'(prog_value);
            if (prog_sel == 2'd1) m_ext  = int'(prog_value);
            if (prog_sel == 2'd2) m_yel  = int'(prog_value);
            m_ph = 0;
            m_left = eff(m_base);
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                k = -2;
                case (m_ph)
                    0: if (old_p != 0 || old_w) begin m_ph = 1; m_left = eff(m_ext); end
                       else m_left = eff(m_base);
                    1: begin m_ph = 2; m_left = eff(m_yel); end
                    2: k = next_pending(old_p, -1);
                    3: if (!m_ext_used && traffic_sensor[m_side]) begin
                           m_left = eff(m_ext); m_ext_used = 1'b1;
                       end else begin
                           m_ph = 4; m_left = eff(m_yel);
                       end
                    4: begin
                        k = next_pending(old_p, m_side);
                        if (k < 0 && !old_w) begin m_ph = 0; m_left = eff(m_base); k = -2; end
                    end
                    default: begin m_ph = 0; m_left = eff(m_base); end
                endcase
                if (k >= 0) begin
                    m_ph = 3; m_side = k; m_left = eff(m_base); m_ext_used = 1'b0; clr[k] = 1'b1;
                end else if (k == -1) begin
                    m_ph = 5; m_left = eff(m_ext); wclr = 1'b1;
                end
            end
        end
        m_pend = (old_p & ~clr) | traffic_sensor;
        m_walk = (old_w & !wclr) | walk_req;
    endtask

    task automatic cycle();
        exp_t        e;
        logic [NS-1:0] gs, ys;
        model_step();
        gs = '0;
        ys = '0;
        if (m_ph == 3) gs[m_side] = 1'b1;
        if (m_ph == 4) ys[m_side] = 1'b1;
        e.lamps    = {m_ph <= 1, m_ph == 2, m_ph > 2, gs, ys, ~(gs | ys), m_ph == 5, 3'(m_ph)};
        e.side     = 3'(m_side);
        e.chk_side = (m_ph == 3) || (m_ph == 4) || !reset;
        exp_q.push_back(e);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        traffic_sensor = '0; walk_req = 1'b0; reprogram = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse(input logic [NS-1:0] s, input logic w);
        traffic_sensor = s; walk_req = w;
        cycle();
        traffic_sensor = '0; walk_req = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 100 && m_ph != ph; i++) cycle();
    endtask

    task automatic prog(input logic [1:0] sel, input logic [CW-1:0] val);
        reprogram = 1'b1; prog_sel = sel; prog_value = val;
        cycle();
        reprogram = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("lamps_phase", 32'({Gm, Ym, Rm, Gs, Ys, Rs, W, phase}), 32'(e.lamps));
                if (e.chk_side) check("side_idx", 32'(side_idx), 32'(e.side));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b0; tick = 1'b1; walk_req = 1'b0; reprogram = 1'b0;
        traffic_sensor = '0; prog_sel = '0; prog_value = '0;
        cycle(); cycle();
        reset = 1'b1;
        idle(30);                          // idle: main green only
        pulse(2'b10, 1'b0); idle(40);      // side 1 only
        pulse(2'b11, 1'b1); idle(60);      // both sides then walk
        traffic_sensor = 2'b01;            // held sensor: single extension
        for (int i = 0; i < 40; i++) cycle();
        idle(30);
        pulse(2'b01, 1'b0); wait_phase(3);
        prog(2'd2, 4'd5);                  // long yellow, restart in main green
        pulse(2'b10, 1'b0); idle(40);
        prog(2'd0, 4'd0);                  // zero base interval acts as one
        pulse(2'b01, 1'b0); idle(30);
        pulse(2'b00, 1'b1); wait_phase(5);
        pulse(2'b00, 1'b1);                // re-arm walk, then reset mid-walk
        reset = 1'b0; cycle(); reset = 1'b1;
        idle(30);
        for (int i = 0; i < 1500; i++) begin
            tick           = ($urandom_range(0, 9) < 8);
            traffic_sensor = NS'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
            walk_req       = ($urandom_range(0, 15) == 0);
            reprogram      = ($urandom_range(0, 99) == 0);
            prog_sel       = 2'($urandom_range(0, 3));
            prog_value     = CW'($urandom_range(0, 7));
            reset          = ($urandom_range(0, 299) != 0);
            cycle();
        end
        reset = 1'b1; tick = 1'b1;
        idle(20);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
